// File: rtl/writeback_port_arbiter.sv
// writeback_port_arbiter
// Merges two execute-unit result streams onto one registered writeback/commit port.
// Each input owns a one-entry holding buffer. When both inputs present a result, the one
// closest to retirement (smallest ROB age relative to next_retire_id) goes first, and
// input 0 wins a tie. The losing result stays in its buffer. The winner is registered
// onto out_* one cycle later. A flush empties both buffers and cancels the pending grant.
module writeback_port_arbiter #(
  parameter int ROB_ID_W = 6,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [ROB_ID_W-1:0] next_retire_id,

  input  logic                in0_valid,
  output logic                in0_ready,
  input  logic [ROB_ID_W-1:0] in0_rob_id,
  input  logic                in0_wen,
  input  logic [PREG_W-1:0]   in0_preg,
  input  logic [DATA_W-1:0]   in0_data,

  input  logic                in1_valid,
  output logic                in1_ready,
  input  logic [ROB_ID_W-1:0] in1_rob_id,
  input  logic                in1_wen,
  input  logic [PREG_W-1:0]   in1_preg,
  input  logic [DATA_W-1:0]   in1_data,

  output logic                out_valid,
  output logic [ROB_ID_W-1:0] out_rob_id,
  output logic                out_wen,
  output logic [PREG_W-1:0]   out_preg,
  output logic [DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]    conflict_cnt
);

  localparam int NUM_IN = 2;

  // ---------------------------------------------------------------------------
  // Gather the two ports into indexable arrays so per-input logic can be generated.
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0] in_valid;
  logic [ROB_ID_W-1:0] in_rob_id [NUM_IN];
  logic [NUM_IN-1:0] in_wen;
  logic [PREG_W-1:0] in_preg [NUM_IN];
  logic [DATA_W-1:0] in_data [NUM_IN];

  assign in_valid     = {in1_valid, in0_valid};
  assign in_wen       = {in1_wen, in0_wen};
  assign in_rob_id[0] = in0_rob_id;
  assign in_rob_id[1] = in1_rob_id;
  assign in_preg[0]   = in0_preg;
  assign in_preg[1]   = in1_preg;
  assign in_data[0]   = in0_data;
  assign in_data[1]   = in1_data;

  // Per-input candidate presented to the arbiter.
  logic [NUM_IN-1:0] cand_valid;
  logic [ROB_ID_W-1:0] cand_rob_id [NUM_IN];
  logic [NUM_IN-1:0] cand_wen;
  logic [PREG_W-1:0] cand_preg [NUM_IN];
  logic [DATA_W-1:0] cand_data [NUM_IN];
  logic [ROB_ID_W-1:0] cand_age [NUM_IN];

  // Arbitration result. A grant is raw here. Flush and reset gate the state updates
  // that consume it.
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] ready;
  logic              both_valid;

  // ---------------------------------------------------------------------------
  // Per-input holding buffer and candidate selection
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_port
    logic                buf_valid_reg;
    logic                buf_valid_next;
    logic                buf_load;
    logic [ROB_ID_W-1:0] buf_rob_id_reg;
    logic                buf_wen_reg;
    logic [PREG_W-1:0]   buf_preg_reg;
    logic [DATA_W-1:0]   buf_data_reg;

    // A buffered entry is older than anything on the live input, so it always goes first.
    assign cand_valid[gi]  = buf_valid_reg | in_valid[gi];
    assign cand_rob_id[gi] = buf_valid_reg ? buf_rob_id_reg : in_rob_id[gi];
    assign cand_wen[gi]    = buf_valid_reg ? buf_wen_reg    : in_wen[gi];
    assign cand_preg[gi]   = buf_valid_reg ? buf_preg_reg   : in_preg[gi];
    assign cand_data[gi]   = buf_valid_reg ? buf_data_reg   : in_data[gi];

    // Modular distance from the retire pointer. The subtraction wraps naturally at
    // 2^ROB_ID_W.
    assign cand_age[gi] = cand_rob_id[gi] - next_retire_id;

    // Room exists when the buffer is empty or is being drained this cycle. This does
    // not depend on in_valid.
    assign ready[gi] = !flush && !rst && (!buf_valid_reg || grant[gi]);

    // Buffer occupancy and load decision for the coming edge.
    always_comb begin
      buf_valid_next = buf_valid_reg;
      buf_load       = 1'b0;
      if (rst || flush) begin
        buf_valid_next = 1'b0;
      end else if (buf_valid_reg) begin
        // Full: drains only when granted; a live result may refill it on the same edge.
        if (grant[gi]) begin
          buf_valid_next = in_valid[gi];
          buf_load       = in_valid[gi];
        end
      end else if (in_valid[gi] && !grant[gi]) begin
        // Empty and the live result lost arbitration: park it.
        buf_valid_next = 1'b1;
        buf_load       = 1'b1;
      end
    end

    // Buffer state register; payload fields only move when a new result is parked.
    always_ff @(posedge clk) begin
      buf_valid_reg <= buf_valid_next;
      if (buf_load) begin
        buf_rob_id_reg <= in_rob_id[gi];
        buf_wen_reg    <= in_wen[gi];
        buf_preg_reg   <= in_preg[gi];
        buf_data_reg   <= in_data[gi];
      end
    end
  end

  assign in0_ready = ready[0];
  assign in1_ready = ready[1];

  // ---------------------------------------------------------------------------
  // Age-based arbitration between the two candidates
  // ---------------------------------------------------------------------------
  logic                sel_in1;
  logic [ROB_ID_W-1:0] win_rob_id;
  logic                win_wen;
  logic [PREG_W-1:0]   win_preg;
  logic [DATA_W-1:0]   win_data;

  // Pick the older candidate; input 0 keeps ties so the choice is deterministic.
  always_comb begin
    both_valid = cand_valid[0] & cand_valid[1];
    sel_in1    = 1'b0;
    if (cand_valid[1]) begin
      if (!cand_valid[0]) begin
        sel_in1 = 1'b1;
      end else if (cand_age[1] < cand_age[0]) begin
        sel_in1 = 1'b1;
      end
    end
    grant[1]   = sel_in1;
    grant[0]   = cand_valid[0] & ~sel_in1;
    win_rob_id = sel_in1 ? cand_rob_id[1] : cand_rob_id[0];
    win_wen    = sel_in1 ? cand_wen[1]    : cand_wen[0];
    win_preg   = sel_in1 ? cand_preg[1]   : cand_preg[0];
    win_data   = sel_in1 ? cand_data[1]   : cand_data[0];
  end

  // ---------------------------------------------------------------------------
  // Registered commit port
  // ---------------------------------------------------------------------------
  logic                out_valid_reg;
  logic [ROB_ID_W-1:0] out_rob_id_reg;
  logic                out_wen_reg;
  logic [PREG_W-1:0]   out_preg_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [CNT_W-1:0]    conflict_cnt_reg;

  // Register the winner. With no grant, the payload holds and only valid and wen drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_rob_id_reg <= '0;
      out_wen_reg    <= 1'b0;
      out_preg_reg   <= '0;
      out_data_reg   <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_wen_reg   <= 1'b0;
    end else if (|grant) begin
      out_valid_reg  <= 1'b1;
      out_rob_id_reg <= win_rob_id;
      out_wen_reg    <= win_wen;
      out_preg_reg   <= win_preg;
      out_data_reg   <= win_data;
    end else begin
      out_valid_reg <= 1'b0;
      out_wen_reg   <= 1'b0;
    end
  end

  // Count cycles in which both inputs competed. The count saturates at all-ones and
  // flush cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if (!flush && both_valid && (conflict_cnt_reg != {CNT_W{1'b1}})) begin
      conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_rob_id   = out_rob_id_reg;
  assign out_wen      = out_wen_reg;
  assign out_preg     = out_preg_reg;
  assign out_data     = out_data_reg;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// tb_writeback_port_arbiter
// Directed scenarios for the two-input writeback arbiter.
// A queue-based model predicts ready and the commit port, and it is checked every cycle.
// Literal expectations pin the model in each scenario.
module tb_writeback_port_arbiter;
  localparam int RW = 6;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic [RW-1:0] rob;
    logic          wen;
    logic [PW-1:0] preg;
    logic [DW-1:0] data;
  } item_t;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [RW-1:0] next_retire_id;
  logic          in0_valid, in0_ready, in0_wen;
  logic [RW-1:0] in0_rob_id;
  logic [PW-1:0] in0_preg;
  logic [DW-1:0] in0_data;
  logic          in1_valid, in1_ready, in1_wen;
  logic [RW-1:0] in1_rob_id;
  logic [PW-1:0] in1_preg;
  logic [DW-1:0] in1_data;
  logic          out_valid, out_wen;
  logic [RW-1:0] out_rob_id;
  logic [PW-1:0] out_preg;
  logic [DW-1:0] out_data;
  logic [CW-1:0] conflict_cnt;

  writeback_port_arbiter #(.ROB_ID_W(RW), .PREG_W(PW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .next_retire_id(next_retire_id),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_rob_id(in0_rob_id),
    .in0_wen(in0_wen), .in0_preg(in0_preg), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_rob_id(in1_rob_id),
    .in1_wen(in1_wen), .in1_preg(in1_preg), .in1_data(in1_data),
    .out_valid(out_valid), .out_rob_id(out_rob_id), .out_wen(out_wen),
    .out_preg(out_preg), .out_data(out_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic item_t mk(input int rob, input bit wen, input int preg, input int data);
    item_t it;
    it.rob  = RW'(rob);
    it.wen  = wen;
    it.preg = PW'(preg);
    it.data = DW'(data);
    return it;
  endfunction

  // ---------------------------------------------------------------- sources
  item_t src0[$], src1[$];

  task automatic drive();
    item_t z;
    z = '0;
    if (src0.size() > 0) z = src0[0];
    in0_valid  = (src0.size() > 0);
    in0_rob_id = z.rob; in0_wen = z.wen; in0_preg = z.preg; in0_data = z.data;
    z = '0;
    if (src1.size() > 0) z = src1[0];
    in1_valid  = (src1.size() > 0);
    in1_rob_id = z.rob; in1_wen = z.wen; in1_preg = z.preg; in1_data = z.data;
  endtask

  // One clock. Each source pops its head only when the handshake completes.
  task automatic cycle();
    bit a0, a1;
    @(negedge clk);
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    @(posedge clk);
    #1;
    if (a0) void'(src0.pop_front());
    if (a1) void'(src1.pop_front());
    drive();
  endtask

  // ---------------------------------------------------------------- model
  // Each model queue holds the results accepted from one input but not yet committed.
  item_t         mq0[$], mq1[$];
  bit            model_live = 0;
  logic          e_valid, e_wen;
  logic [RW-1:0] e_rob;
  logic [PW-1:0] e_preg;
  logic [DW-1:0] e_data;
  logic [CW-1:0] e_cnt;
  logic [RW-1:0] out_log[$];

  item_t m_c0, m_c1, m_l0, m_l1;
  bit    m_h0, m_h1, m_r0, m_r1;
  int    m_a0, m_a1, m_w, m_s0, m_s1;

  // Compare the DUT against the model, then advance the model by one clock.
  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", out_valid, e_valid);
      chk("out_wen", out_wen, e_wen);
      chk("out_rob_id", out_rob_id, e_rob);
      chk("out_preg", out_preg, e_preg);
      chk("out_data", out_data, e_data);
      chk("conflict_cnt", conflict_cnt, e_cnt);
      if (out_valid === 1'b1) out_log.push_back(out_rob_id);
    end
    m_l0 = mk(int'(in0_rob_id), in0_wen, int'(in0_preg), int'(in0_data));
    m_l1 = mk(int'(in1_rob_id), in1_wen, int'(in1_preg), int'(in1_data));
    m_s0 = mq0.size();
    m_s1 = mq1.size();
    m_h0 = (m_s0 > 0) || (in0_valid === 1'b1);
    m_h1 = (m_s1 > 0) || (in1_valid === 1'b1);
    m_c0 = (m_s0 > 0) ? mq0[0] : m_l0;
    m_c1 = (m_s1 > 0) ? mq1[0] : m_l1;
    m_w = -1;
    if (!rst && !flush) begin
      m_a0 = (int'(m_c0.rob) - int'(next_retire_id) + 64) % 64;
      m_a1 = (int'(m_c1.rob) - int'(next_retire_id) + 64) % 64;
      if (m_h0 && m_h1) begin
        m_w = (m_a0 <= m_a1) ? 0 : 1;
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 1'b1;
      end else if (m_h0) m_w = 0;
      else if (m_h1) m_w = 1;
    end
    m_r0 = !rst && !flush && (m_s0 == 0 || m_w == 0);
    m_r1 = !rst && !flush && (m_s1 == 0 || m_w == 1);
    if (model_live || rst) begin
      chk("in0_ready", in0_ready, m_r0);
      chk("in1_ready", in1_ready, m_r1);
    end
    if (rst) begin
      mq0.delete(); mq1.delete();
      e_valid = 0; e_wen = 0; e_rob = '0; e_preg = '0; e_data = '0; e_cnt = '0;
      model_live = 1;
    end else if (flush) begin
      mq0.delete(); mq1.delete();
      e_valid = 0; e_wen = 0;
    end else begin
      if (m_w == 0) begin
        e_valid = 1; e_rob = m_c0.rob; e_wen = m_c0.wen; e_preg = m_c0.preg; e_data = m_c0.data;
        if (m_s0 > 0) void'(mq0.pop_front());
      end else if (m_w == 1) begin
        e_valid = 1; e_rob = m_c1.rob; e_wen = m_c1.wen; e_preg = m_c1.preg; e_data = m_c1.data;
        if (m_s1 > 0) void'(mq1.pop_front());
      end else begin
        e_valid = 0; e_wen = 0;
      end
      // Accepted live results that did not go straight out stay pending.
      if (in0_valid === 1'b1 && m_r0 && !(m_s0 == 0 && m_w == 0)) mq0.push_back(m_l0);
      if (in1_valid === 1'b1 && m_r1 && !(m_s1 == 0 && m_w == 1)) mq1.push_back(m_l1);
    end
  end

  // ---------------------------------------------------------------- stimulus
  int t4_exp[6] = '{1, 2, 3, 4, 20, 21};
  bit saw9;

  initial begin
    rst = 1; flush = 0; next_retire_id = '0;
    drive();
    cycle();
    cycle();
    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rob_id", out_rob_id, 0);
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_in0_ready", in0_ready, 0);
    rst = 0;
    #1;
    chk("post_rst_in1_ready", in1_ready, 1);

    // T1 single result
    src0.push_back(mk(5, 1, 3, 'hAA));
    drive();
    #1;
    chk("t1_in0_ready", in0_ready, 1);
    cycle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_rob", out_rob_id, 5);
    chk("t1_out_preg", out_preg, 3);
    chk("t1_out_data", out_data, 'hAA);
    chk("t1_out_wen", out_wen, 1);
    cycle();
    chk("t1_out_idle", out_valid, 0);

    // T2 conflict: age(10)=6 and age(7)=3, so input 1 goes first.
    next_retire_id = 6'd4;
    src0.push_back(mk(10, 1, 12, 'h1010));
    src1.push_back(mk(7, 0, 13, 'h0707));
    drive();
    #1;
    chk("t2_in0_ready", in0_ready, 1);
    chk("t2_in1_ready", in1_ready, 1);
    cycle();
    chk("t2_first_rob", out_rob_id, 7);
    chk("t2_first_wen", out_wen, 0);
    cycle();
    chk("t2_second_rob", out_rob_id, 10);
    chk("t2_second_valid", out_valid, 1);
    chk("t2_conflict", conflict_cnt, 1);
    cycle();

    // T3 wrap: retire=60, rob 2 has age 6 and rob 62 has age 2.
    next_retire_id = 6'd60;
    src0.push_back(mk(2, 1, 1, 'h22));
    src1.push_back(mk(62, 1, 2, 'h62));
    drive();
    cycle();
    chk("t3_first_rob", out_rob_id, 62);
    cycle();
    chk("t3_second_rob", out_rob_id, 2);
    cycle();

    // T4 backpressure
    next_retire_id = '0;
    out_log.delete();
    for (int i = 1; i <= 4; i++) src1.push_back(mk(i, 1, i, 'h100 + i));
    src0.push_back(mk(20, 1, 20, 'h200));
    src0.push_back(mk(21, 1, 21, 'h201));
    drive();
    cycle();
    #1;
    chk("t4_in0_blocked", in0_ready, 0);
    chk("t4_in1_open", in1_ready, 1);
    repeat (7) cycle();
    chk("t4_count", out_log.size(), 6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      chk($sformatf("t4_order%0d", i), out_log[i], t4_exp[i]);

    // T5 flush while rob 9 is parked in buf_0
    out_log.delete();
    src0.push_back(mk(9, 1, 9, 'h99));
    src1.push_back(mk(3, 1, 3, 'h33));
    src1.push_back(mk(4, 1, 4, 'h44));
    drive();
    cycle();
    chk("t5_pre_rob", out_rob_id, 3);
    flush = 1;
    #1;
    chk("t5_flush_in0_ready", in0_ready, 0);
    chk("t5_flush_in1_ready", in1_ready, 0);
    cycle();
    flush = 0;
    src0.delete();
    src1.delete();
    drive();
    chk("t5_out_cleared", out_valid, 0);
    repeat (4) cycle();
    saw9 = 0;
    foreach (out_log[i]) if (out_log[i] == 6'd9) saw9 = 1;
    chk("t5_no_rob9", saw9, 0);
    chk("t5_log", out_log.size(), 1);

    // T6 reset mid-operation with both buffers full and three conflicts counted
    rst = 1;
    cycle();
    rst = 0;
    src0.push_back(mk(30, 1, 30, 'h300));
    src0.push_back(mk(31, 1, 31, 'h301));
    src0.push_back(mk(32, 1, 32, 'h302));
    src1.push_back(mk(5, 1, 5, 'h500));
    src1.push_back(mk(40, 1, 40, 'h400));
    drive();
    repeat (3) cycle();
    chk("t6_conflict3", conflict_cnt, 3);
    chk("t6_in1_blocked", in1_ready, 0);
    rst = 1;
    #1;
    chk("t6_rst_in0_ready", in0_ready, 0);
    chk("t6_rst_in1_ready", in1_ready, 0);
    cycle();
    rst = 0;
    out_log.delete();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_rob", out_rob_id, 0);
    chk("t6_out_preg", out_preg, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_wen", out_wen, 0);
    chk("t6_conflict0", conflict_cnt, 0);
    #1;
    chk("t6_after_in0_ready", in0_ready, 1);
    chk("t6_after_in1_ready", in1_ready, 1);
    repeat (3) cycle();
    chk("t6_buffers_dropped", out_log.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
